// File: rtl/oc_drain.sv
// oc_drain: captures one NUM_LANE-wide result vector plus its mode tag and
// streams it out as NUM_BEAT beats of BEAT_LANES lanes over valid/ready.
// A new vector may be captured on the handshake of the last beat, so
// back-to-back vectors drain without a bubble.
module oc_drain #(
  parameter  int NUM_LANE   = 64,
  parameter  int BW         = 16,
  parameter  int BEAT_LANES = 8,
  localparam int NUM_BEAT   = NUM_LANE / BEAT_LANES,
  localparam int IDX_W      = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_LANE-1:0][BW-1:0]      iC,
  input  logic [1:0]                       iMode,
  input  logic                             iC_valid,
  output logic                             iC_ready,
  output logic [BEAT_LANES-1:0][BW-1:0]    oBeat,
  output logic [IDX_W-1:0]                 oBeat_idx,
  output logic [1:0]                       oBeat_mode,
  output logic                             oBeat_last,
  output logic                             oBeat_valid,
  input  logic                             oBeat_ready,
  output logic [15:0]                      oFrame_cnt
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEAT - 1);

  state_t state_q;
  state_t state_d;

  // Captured vector viewed as beats of lanes so a beat is one index away.
  logic [NUM_BEAT-1:0][BEAT_LANES-1:0][BW-1:0] vec_p1;
  logic [1:0]                                  mode_p1;
  logic [IDX_W-1:0]                            idx_p1;
  logic [15:0]                                 frame_cnt_p1;

  logic is_last;
  logic beat_hs;
  logic capture;

  assign is_last = (idx_p1 == LAST_IDX);
  assign beat_hs = oBeat_valid & oBeat_ready;
  assign capture = iC_valid & iC_ready;

  // State register; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave DRAIN only on the last-beat handshake without a reload.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture) state_d = DRAIN;
      DRAIN:   if (beat_hs && is_last) state_d = capture ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; iC_ready looks through oBeat_ready so the reload
  // can land on the very cycle the last beat leaves.
  always_comb begin
    oBeat_valid = (state_q == DRAIN);
    iC_ready    = (state_q == IDLE) | ((state_q == DRAIN) & oBeat_ready & is_last);
  end

  // ---- capture / beat stage: vector, tag and beat index ----
  // Buffer only changes on capture; the index advances per beat handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_p1  <= '0;
      mode_p1 <= 2'd0;
      idx_p1  <= '0;
    end else if (capture) begin
      vec_p1  <= iC;
      mode_p1 <= iMode;
      idx_p1  <= '0;
    end else if (beat_hs) begin
      idx_p1  <= is_last ? '0 : idx_p1 + IDX_W'(1);
    end
  end

  // Count fully drained vectors; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                frame_cnt_p1 <= 16'd0;
    else if (beat_hs && is_last) frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
  end

  assign oBeat      = vec_p1[idx_p1];
  assign oBeat_idx  = idx_p1;
  assign oBeat_mode = mode_p1;
  assign oBeat_last = is_last;
  assign oFrame_cnt = frame_cnt_p1;

endmodule

// File: tb/tb_oc_drain.sv
// Bench for oc_drain: directed scenarios plus a randomized phase, all checked
// against a queue-of-beats reference model.
module tb_oc_drain;

  localparam int NL = 64;
  localparam int BW = 16;
  localparam int BL = 8;
  localparam int NB = NL / BL;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NL-1:0][BW-1:0]   iC;
  logic [1:0]              iMode;
  logic                    iC_valid;
  logic                    iC_ready;
  logic [BL-1:0][BW-1:0]   oBeat;
  logic [2:0]              oBeat_idx;
  logic [1:0]              oBeat_mode;
  logic                    oBeat_last;
  logic                    oBeat_valid;
  logic                    oBeat_ready;
  logic [15:0]             oFrame_cnt;

  oc_drain #(.NUM_LANE(NL), .BW(BW), .BEAT_LANES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .iC(iC), .iMode(iMode), .iC_valid(iC_valid),
    .iC_ready(iC_ready), .oBeat(oBeat), .oBeat_idx(oBeat_idx),
    .oBeat_mode(oBeat_mode), .oBeat_last(oBeat_last), .oBeat_valid(oBeat_valid),
    .oBeat_ready(oBeat_ready), .oFrame_cnt(oFrame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BL-1:0][BW-1:0] data;
    logic [2:0]            idx;
    logic [1:0]            mode;
    logic                  last;
  } beat_t;

  beat_t       q[$];
  logic [15:0] cnt_m;
  bit          acc_m;
  int          vcycles;
  int          stall_cnt;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check and advance the model at the falling edge, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    bit    exp_ready;
    beat_t b;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      cnt_m = 16'd0;
      acc_m = 1'b0;
    end else begin
      exp_ready = (q.size() == 0) || (q.size() == 1 && oBeat_ready);
      chk("ic_ready", iC_ready, exp_ready);
      chk("valid", oBeat_valid, q.size() != 0);
      chk("frame_cnt", oFrame_cnt, cnt_m);
      if (oBeat_valid) vcycles++;
      if (iC_valid && !iC_ready) stall_cnt++;
      if (q.size() != 0) begin
        chk("beat_data", oBeat, q[0].data);
        chk("beat_idx", oBeat_idx, q[0].idx);
        chk("beat_mode", oBeat_mode, q[0].mode);
        chk("beat_last", oBeat_last, q[0].last);
        if (oBeat_ready) begin
          if (q[0].last) cnt_m = cnt_m + 16'd1;
          void'(q.pop_front());
        end
      end
      acc_m = iC_valid && exp_ready;
      if (acc_m) begin
        for (int k = 0; k < NB; k++) begin
          for (int j = 0; j < BL; j++) b.data[j] = iC[k*BL + j];
          b.idx  = 3'(k);
          b.mode = iMode;
          b.last = (k == NB - 1);
          q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(input logic [1:0] m);
    for (int i = 0; i < NL; i++) iC[i] = 16'($urandom);
    iMode    = m;
    iC_valid = 1'b1;
  endtask

  task automatic wait_accept(input int bound);
    bit got;
    got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      step();
      got = acc_m;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no capture expected capture within %0d cycles", bound);
    end
  endtask

  int v0;
  int s0;

  initial begin
    rst_n = 1'b0; iC = '0; iMode = 2'd0; iC_valid = 1'b0; oBeat_ready = 1'b0;
    cnt_m = 16'd0; acc_m = 1'b0; vcycles = 0; stall_cnt = 0; n_cmp = 0; n_err = 0;
    repeat (2) step();
    chk("reset_valid", oBeat_valid, 1'b0);
    chk("reset_frame", oFrame_cnt, 16'd0);
    rst_n = 1'b1;
    step();

    // Single vector, lane i = i, mode 2, always ready.
    for (int i = 0; i < NL; i++) iC[i] = 16'(i);
    iMode = 2'd2; iC_valid = 1'b1; oBeat_ready = 1'b1;
    wait_accept(4);
    iC_valid = 1'b0;
    chk("t2_beat0_lane7", oBeat[7], 16'd7);
    v0 = vcycles;
    repeat (NB) step();
    chk("t2_beats", vcycles - v0, NB);
    chk("t2_frame", oFrame_cnt, 16'd1);
    chk("t2_idle", oBeat_valid, 1'b0);

    // Asynchronous reset away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_valid", oBeat_valid, 1'b0);
    chk("t1_async_frame", oFrame_cnt, 16'd0);
    step();
    #1 rst_n = 1'b1;
    #1;
    chk("t1_ready_after", iC_ready, 1'b1);

    // Backpressure on beat 3 for five cycles.
    rand_vec(2'd1);
    wait_accept(4);
    iC_valid = 1'b0;
    v0 = vcycles;
    for (int c = 1; c <= 13; c++) begin
      oBeat_ready = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      step();
    end
    chk("t3_drain_cycles", vcycles - v0, 13);
    chk("t3_frame", oFrame_cnt, 16'd1);

    // Back-to-back: B held while A drains, captured on A's last beat.
    oBeat_ready = 1'b1;
    rand_vec(2'd0);
    wait_accept(4);
    v0 = vcycles;
    rand_vec(2'd3);
    wait_accept(12);
    iC_valid = 1'b0;
    repeat (NB) step();
    chk("t4_valid_beats", vcycles - v0, 2 * NB);
    chk("t4_frame", oFrame_cnt, 16'd3);

    // Upstream stall: B presented while A shows beat 2.
    rand_vec(2'd1);
    wait_accept(4);
    iC_valid = 1'b0;
    repeat (2) step();
    chk("t5_idx_at_present", oBeat_idx, 3'd2);
    s0 = stall_cnt;
    rand_vec(2'd2);
    wait_accept(12);
    chk("t5_stall_cycles", stall_cnt - s0, 5);
    iC_valid = 1'b0;
    repeat (NB) step();
    chk("t5_frame", oFrame_cnt, 16'd5);

    // Reset while beat 4 is on the bus.
    rand_vec(2'd3);
    wait_accept(4);
    iC_valid = 1'b0;
    repeat (4) step();
    chk("t6_idx_before", oBeat_idx, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", oBeat_valid, 1'b0);
    chk("t6_frame", oFrame_cnt, 16'd0);
    chk("t6_idx", oBeat_idx, 3'd0);
    step();
    rst_n = 1'b1;
    rand_vec(2'd0);
    wait_accept(4);
    iC_valid = 1'b0;
    repeat (NB) step();
    chk("t6_frame_after", oFrame_cnt, 16'd1);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      oBeat_ready = ($urandom_range(0, 3) != 0);
      if (!iC_valid || acc_m) begin
        if ($urandom_range(0, 1) == 1) rand_vec(2'($urandom));
        else begin
          iC_valid = 1'b0;
          for (int i = 0; i < NL; i++) iC[i] = 16'($urandom);
          iMode = 2'($urandom);
        end
      end
      step();
    end

    // Drain everything left.
    oBeat_ready = 1'b1;
    if (iC_valid && !acc_m) wait_accept(20);
    iC_valid = 1'b0;
    repeat (NB + 2) step();
    chk("final_idle", oBeat_valid, 1'b0);
    chk("final_frame", oFrame_cnt, cnt_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
